led_frame_sequencer: RTL and testbench
======================================

// Module: led_frame_sequencer
// PURPOSE
//  Frame scheduler for the WS2812B chain on the 8x8 cube face panel.
//  - On request, walks every LED in wire (serpentine, column-major) order.
//  - Fetches each pixel's 24-bit {BB,RR,GG} word from a row-major frame RAM.
//  - Applies global brightness, hands the word to the bit serializer, waits for completion.
//  - Closes the frame with the latch/reset gap.
//  - Sits between the frame RAM (filled by the SPI orientation path) and make_data_stream.
// PARAMETERS
//  WIDTH         8     panel columns
//  HEIGHT        8     panel rows; NUM_LEDS = WIDTH*HEIGHT
//  ADDR_W        6     frame RAM address width, >= clog2(WIDTH*HEIGHT)
//  LATCH_CYCLES  2400  low-time after last pixel (60 us at 40 MHz); >= 2
// PORTS
//  clk            in   1       40 MHz system clock
//  reset          in   1       synchronous, active-high
//  frame_req      in   1       pulse or level; request one full frame refresh
//  brightness     in   8       global scale, sampled at frame start
//  frame_busy     out  1       high from frame accept until frame_done
//  frame_done     out  1       1-cycle pulse at end of latch gap
//  pix_rd         out  1       frame RAM read strobe
//  pix_addr       out  ADDR_W  frame RAM address = row*WIDTH + col
//  pix_data       in   24      RAM read data, valid exactly 1 cycle after pix_rd
//  ser_start      out  1       1-cycle pulse; serializer loads ser_data
//  ser_data       out  24      scaled pixel word, held stable until ser_done
//  ser_done       in   1       1-cycle pulse; serializer finished 24 bits
//  latch_active   out  1       high during latch gap; serializer line must be low
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; counters 0; pending flag 0.
//  States: IDLE, FETCH, CAPTURE, LOAD, WAIT_SER, LATCH, DONE.
//  - IDLE: frame_req=1 or pending=1 -> FETCH next cycle.
//    On leaving IDLE: brightness latched, led index/col/row cleared, pending cleared.
//  - FETCH (1 cycle): pix_rd=1, pix_addr from current (row,col) -> CAPTURE.
//  - CAPTURE (1 cycle): register pix_data, scale each byte -> LOAD.
//  - LOAD (1 cycle): ser_start=1 -> WAIT_SER.
//  - WAIT_SER: wait for ser_done (may arrive any cycle after LOAD).
//    Not last LED: advance position -> FETCH.
//    Last LED (index NUM_LEDS-1): -> LATCH, latch counter cleared.
//  - LATCH: latch_active=1 for exactly LATCH_CYCLES cycles -> DONE.
//  - DONE (1 cycle): frame_done=1 -> IDLE.
//  frame_busy = (state != IDLE).
//  Min per-pixel overhead: 3 cycles + serializer time.
//  Serpentine order (counters, no divide):
//  - col runs 0..WIDTH-1.
//  - Even col: row walks 0 -> HEIGHT-1. Odd col: row walks HEIGHT-1 -> 0.
//  - At column end: col+1, row set to the new column's start row.
//  - Index 0 -> addr 0; index HEIGHT -> addr (HEIGHT-1)*WIDTH + 1.
//  Brightness: per byte, out = (byte * (brightness+1)) >> 8, 8x9-bit product, bits [15:8].
//  - 255 is identity; 0 maps 255 -> 0.
//  - Three independent bytes; no carry between them.
//  Boundaries:
//  - frame_req while busy: set 1-deep pending flag; extra requests are merged.
//  - Pending frame starts on the cycle after DONE; frame_busy stays low for that 1 IDLE cycle.
//  - frame_req coincident with DONE: becomes pending.
//  - ser_done outside WAIT_SER: ignored.
//  - ser_data changes only in CAPTURE.
//  - brightness changes mid-frame: no effect until the next frame.
//  - reset mid-frame: immediate return to reset values next cycle.
//    No frame_done pulse; pending request discarded.
// TESTING
//  1. Reset, frame_req pulse, serializer model ser_done 5 cycles after ser_start, WIDTH=HEIGHT=8
//     -> 64 ser_starts; pix_addr sequence 0,8,...,56,57,49,...,1,2,...; latch 2400 cycles; one frame_done.
//  2. RAM word 24'h80F060, brightness=255 -> ser_data=80F060.
//     brightness=127 -> 407830. brightness=0 -> 000000.
//  3. frame_req pulsed 3 times mid-frame -> exactly one more frame, starting 2 cycles after frame_done.
//  4. Change brightness mid-frame from 255 to 0 -> current frame keeps identity; next frame all zero.
//  5. Assert reset during pixel 10 WAIT_SER -> next cycle all outputs 0; no frame_done;
//     new frame_req restarts at addr 0.
//  6. ser_done held off 100 cycles -> ser_data stable, no new pix_rd, frame_busy high throughout.

Source files
------------

// File: rtl/led_frame_if.sv
// Signal bundle between the LED frame sequencer, the frame RAM and the bit serializer.
// The sequencer uses the master view; the RAM/serializer side uses the slave view.
interface led_frame_if #(
  parameter int ADDR_W = 6
);
  logic              frame_req;
  logic [7:0]        brightness;
  logic              frame_busy;
  logic              frame_done;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic              ser_start;
  logic [23:0]       ser_data;
  logic              ser_done;
  logic              latch_active;

  modport master (
    input  frame_req, brightness, pix_data, ser_done,
    output frame_busy, frame_done, pix_rd, pix_addr, ser_start, ser_data, latch_active
  );

  modport slave (
    output frame_req, brightness, pix_data, ser_done,
    input  frame_busy, frame_done, pix_rd, pix_addr, ser_start, ser_data, latch_active
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Walks the WS2812B chain in serpentine column-major order, fetches and scales each pixel,
// feeds the serializer, then holds the latch gap before reporting frame_done.
//
// state    | meaning
// IDLE     | waiting for frame_req or a pending request
// FETCH    | frame RAM read strobe for the current (row,col)
// CAPTURE  | RAM data valid; scale and register into ser_data
// LOAD     | ser_start pulse
// WAIT_SER | waiting for ser_done, then advance or finish
// LATCH    | line held low for LATCH_CYCLES
// DONE     | frame_done pulse
module led_frame_sequencer #(
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 8,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 2400
) (
  input  logic        clk,
  input  logic        reset,
  led_frame_if.master bus
);
  localparam int NUM_LEDS = WIDTH * HEIGHT;
  localparam int CW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
  localparam int RW = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1;
  localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = $clog2(LATCH_CYCLES);

  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOAD, WAIT_SER, LATCH, DONE} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  bright_q, bright_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [23:0] ser_data_q, ser_data_d;
  logic [ADDR_W-1:0] addr_cur;

  // out = (v * (b+1)) >> 8; the product tops out at 255*256 so 16 bits suffice
  function automatic logic [7:0] scale(input logic [7:0] v, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(v) * (16'(b) + 16'd1);
    return 8'(p >> 8);
  endfunction

  assign addr_cur     = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
  assign bus.ser_data = ser_data_q;

  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    bright_d         = bright_q;
    col_d            = col_q;
    row_d            = row_q;
    idx_d            = idx_q;
    lat_d            = lat_q;
    ser_data_d       = ser_data_q;
    bus.frame_busy   = (state_q != IDLE);
    bus.frame_done   = 1'b0;
    bus.pix_rd       = 1'b0;
    bus.pix_addr     = '0;
    bus.ser_start    = 1'b0;
    bus.latch_active = 1'b0;

    if (bus.frame_req && (state_q != IDLE)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.frame_req || pend_q) begin
          state_d  = FETCH;
          bright_d = bus.brightness;
          col_d    = '0;
          row_d    = '0;
          idx_d    = '0;
          pend_d   = 1'b0;
        end
      end
      FETCH: begin
        bus.pix_rd   = 1'b1;
        bus.pix_addr = addr_cur;
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        ser_data_d = {scale(bus.pix_data[23:16], bright_q),
                      scale(bus.pix_data[15:8],  bright_q),
                      scale(bus.pix_data[7:0],   bright_q)};
        state_d    = LOAD;
      end
      LOAD: begin
        bus.ser_start = 1'b1;
        state_d       = WAIT_SER;
      end
      WAIT_SER: begin
        if (bus.ser_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = LATCH;
            lat_d   = '0;
          end else begin
            state_d = FETCH;
            idx_d   = idx_q + IW'(1);
            // row is kept on a column change: an odd column starts where the even one ended
            if (!col_q[0]) begin
              if (row_q == ROW_LAST) col_d = col_q + CW'(1);
              else                   row_d = row_q + RW'(1);
            end else begin
              if (row_q == '0) col_d = col_q + CW'(1);
              else             row_d = row_q - RW'(1);
            end
          end
        end
      end
      LATCH: begin
        bus.latch_active = 1'b1;
        if (lat_q == LAT_LAST) state_d = DONE;
        else                   lat_d   = lat_q + LW'(1);
      end
      DONE: begin
        bus.frame_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      bright_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      ser_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      bright_q   <= bright_d;
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      ser_data_q <= ser_data_d;
    end
  end
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: frame RAM and serializer models plus one task per scenario.
module tb_led_frame_sequencer;
  localparam int W = 8, H = 8, N = 64, LAT = 2400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_frame_if #(.ADDR_W(6)) bus ();

  led_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(6), .LATCH_CYCLES(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [23:0] ram [N];
  int ser_delay = 5;
  int ser_cnt;

  always @(posedge clk) begin
    if (bus.pix_rd === 1'b1) bus.pix_data <= ram[bus.pix_addr];
  end

  always @(posedge clk) begin
    bus.ser_done <= 1'b0;
    if (reset) ser_cnt <= 0;
    else if (bus.ser_start === 1'b1) ser_cnt <= ser_delay;
    else if (ser_cnt > 0) begin
      ser_cnt <= ser_cnt - 1;
      if (ser_cnt == 1) bus.ser_done <= 1'b1;
    end
  end

  int n_start = 0, n_rd = 0, n_done = 0, n_latch = 0;
  logic [23:0] data_log [256];
  logic [5:0]  addr_log [256];
  always @(posedge clk) begin
    if (bus.ser_start === 1'b1) begin data_log[n_start % 256] = bus.ser_data; n_start++; end
    if (bus.pix_rd === 1'b1) begin addr_log[n_rd % 256] = bus.pix_addr; n_rd++; end
    if (bus.frame_done === 1'b1) n_done++;
    if (bus.latch_active === 1'b1) n_latch++;
  end

  function automatic int exp_addr(input int k);
    int c, r;
    c = k / H;
    r = k % H;
    if (c % 2 == 1) r = H - 1 - r;
    return r * W + c;
  endfunction

  function automatic logic [34:0] all_outs();
    return {bus.frame_busy, bus.frame_done, bus.pix_rd, bus.pix_addr,
            bus.ser_start, bus.ser_data, bus.latch_active};
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk); bus.frame_req = 1'b1;
    @(negedge clk); bus.frame_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_start >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.frame_req = 1'b0;
    bus.brightness = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 35'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 35'd0) begin errors++; $display("FAIL idle_outs: got %h want 0", all_outs()); end
  endtask

  task automatic test_full_frame();
    int bs, br, bl, bd, bad_a, bad_d;
    bit ok;
    do_reset();
    bus.brightness = 8'd255;
    bs = n_start; br = n_rd; bl = n_latch; bd = n_done;
    pulse_req();
    checks++;
    if (bus.frame_busy !== 1'b1 || bus.pix_rd !== 1'b1) begin
      errors++; $display("FAIL first_fetch: busy=%b rd=%b want 1 1", bus.frame_busy, bus.pix_rd);
    end
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame1_done: timeout"); end
    repeat (3) @(negedge clk);
    checks++;
    if (n_start - bs !== N) begin errors++; $display("FAIL ser_starts: got %0d want %0d", n_start - bs, N); end
    checks++;
    if (n_latch - bl !== LAT) begin errors++; $display("FAIL latch_len: got %0d want %0d", n_latch - bl, LAT); end
    checks++;
    if (n_done - bd !== 1) begin errors++; $display("FAIL done_count: got %0d want 1", n_done - bd); end
    checks++;
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b want 0", bus.frame_busy); end
    bad_a = 0; bad_d = 0;
    for (int k = 0; k < N; k++) begin
      if (int'(addr_log[(br + k) % 256]) != exp_addr(k)) bad_a++;
      if (data_log[(bs + k) % 256] !== ram[exp_addr(k)]) bad_d++;
    end
    checks++;
    if (bad_a !== 0) begin errors++; $display("FAIL addr_seq: %0d wrong, want 0 (idx8 got %0d want 57)", bad_a, addr_log[(br + 8) % 256]); end
    checks++;
    if (bad_d !== 0) begin errors++; $display("FAIL data_identity: %0d wrong, want 0", bad_d); end
  endtask

  task automatic test_scaling();
    logic [7:0]  bv [3] = '{8'd255, 8'd127, 8'd0};
    logic [23:0] ev [3] = '{24'h80F060, 24'h407830, 24'h000000};
    int bs;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      bus.brightness = bv[i];
      bs = n_start;
      pulse_req();
      wait_starts(bs + 1, 20, ok);
      checks++;
      if (!ok || data_log[bs % 256] !== ev[i]) begin
        errors++; $display("FAIL scale_b%0d: got %h want %h", bv[i], data_log[bs % 256], ev[i]);
      end
    end
  endtask

  task automatic test_pending();
    int bd;
    bit ok;
    do_reset();
    bus.brightness = 8'd255;
    bd = n_done;
    pulse_req();
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) begin pulse_req(); repeat (7) @(negedge clk); end
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pend_frame1: timeout"); end
    @(negedge clk);
    checks++;
    if (bus.frame_busy !== 1'b0 || bus.pix_rd !== 1'b0) begin
      errors++; $display("FAIL pend_gap: busy=%b rd=%b want 0 0", bus.frame_busy, bus.pix_rd);
    end
    @(negedge clk);
    checks++;
    if (bus.pix_rd !== 1'b1 || bus.pix_addr !== 6'd0 || bus.frame_busy !== 1'b1) begin
      errors++; $display("FAIL pend_restart: rd=%b addr=%0d busy=%b want 1 0 1", bus.pix_rd, bus.pix_addr, bus.frame_busy);
    end
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pend_frame2: timeout"); end
    repeat (50) @(negedge clk);
    checks++;
    if (bus.frame_busy !== 1'b0 || n_done - bd !== 2) begin
      errors++; $display("FAIL pend_merge: busy=%b frames=%0d want 0 2", bus.frame_busy, n_done - bd);
    end
  endtask

  task automatic test_brightness_change();
    int bs, bad1, bad2;
    bit ok;
    do_reset();
    bus.brightness = 8'd255;
    bs = n_start;
    pulse_req();
    repeat (30) @(negedge clk);
    bus.brightness = 8'd0;
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bchg_frame1: timeout"); end
    bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
    checks++;
    if (bus.frame_busy !== 1'b0) begin errors++; $display("FAIL done_req_gap: busy=%b want 0", bus.frame_busy); end
    @(negedge clk);
    checks++;
    if (bus.pix_rd !== 1'b1) begin errors++; $display("FAIL done_req_pending: rd=%b want 1", bus.pix_rd); end
    wait_done(4000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bchg_frame2: timeout"); end
    repeat (3) @(negedge clk);
    bad1 = 0; bad2 = 0;
    for (int k = 0; k < N; k++) begin
      if (data_log[(bs + k) % 256] !== ram[exp_addr(k)]) bad1++;
      if (data_log[(bs + N + k) % 256] !== 24'h000000) bad2++;
    end
    checks++;
    if (bad1 !== 0) begin errors++; $display("FAIL bchg_cur_identity: %0d wrong, want 0", bad1); end
    checks++;
    if (bad2 !== 0) begin errors++; $display("FAIL bchg_next_zero: %0d wrong, want 0", bad2); end
    bus.brightness = 8'd255;
  endtask

  task automatic test_reset_mid();
    int bs, br, bd, bad;
    bit ok;
    do_reset();
    bus.brightness = 8'd255;
    bs = n_start; br = n_rd; bd = n_done;
    pulse_req();
    repeat (5) @(negedge clk);
    pulse_req();
    wait_starts(bs + 11, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reach_px10: timeout"); end
    checks++;
    if (addr_log[(br + 10) % 256] !== 6'd41) begin
      errors++; $display("FAIL px10_addr: got %0d want 41", addr_log[(br + 10) % 256]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== 35'd0) begin errors++; $display("FAIL rst_mid_outs: got %h want 0", all_outs()); end
    reset = 1'b0;
    bad = 0;
    repeat (20) begin @(negedge clk); if (bus.frame_busy !== 1'b0) bad++; end
    checks++;
    if (bad !== 0 || n_done - bd !== 0) begin
      errors++; $display("FAIL rst_discard: busy_cycles=%0d dones=%0d want 0 0", bad, n_done - bd);
    end
    pulse_req();
    checks++;
    if (bus.pix_rd !== 1'b1 || bus.pix_addr !== 6'd0) begin
      errors++; $display("FAIL rst_restart: rd=%b addr=%0d want 1 0", bus.pix_rd, bus.pix_addr);
    end
  endtask

  task automatic test_stall();
    int bs, bad;
    logic [23:0] held;
    bit ok, seen;
    ser_delay = 100;
    do_reset();
    bus.brightness = 8'd255;
    bs = n_start;
    pulse_req();
    wait_starts(bs + 1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_start: timeout"); end
    held = bus.ser_data;
    bad = 0;
    repeat (95) begin
      @(negedge clk);
      if (bus.ser_data !== held || bus.pix_rd !== 1'b0 || bus.frame_busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0 || held !== 24'h80F060) begin
      errors++; $display("FAIL stall_hold: bad_cycles=%0d data=%h want 0 80f060", bad, held);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pix_rd === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || bus.pix_addr !== 6'd8) begin
      errors++; $display("FAIL stall_resume: seen=%b addr=%0d want 1 8", seen, bus.pix_addr);
    end
    ser_delay = 5;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < N; i++) ram[i] = {8'(i * 5 + 3), 8'(250 - i * 2), 8'(i * 3 + 1)};
    ram[0] = 24'h80F060;
    test_reset();
    test_full_frame();
    test_scaling();
    test_pending();
    test_brightness_change();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
